// File: rtl/fnd_pkg.sv
// Shared definitions for the two-digit 7-segment scan driver: segment
// patterns, conversion FSM state type and the BCD add-3 correction.
package fnd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] BLANK = 7'h00;

    // Six input bits need six shift steps; the counter value on the final step.
    localparam logic [2:0] CONV_LAST = 3'd5;

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [7:0] bcd_adjust(input logic [7:0] bcd);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = bcd[7:4];
        lo = bcd[3:0];
        if (hi >= 4'd5) begin
            hi = hi + 4'd3;
        end else begin
            hi = hi;
        end
        if (lo >= 4'd5) begin
            lo = lo + 4'd3;
        end else begin
            lo = lo;
        end
        return {hi, lo};
    endfunction

endpackage

// File: rtl/bcd2seg.sv
// Combinational BCD to 7-segment decoder; non-decimal codes decode to blank.
module bcd2seg
    import fnd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pattern lookup for one BCD digit.
    always_comb begin
        seg = BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = BLANK;
        endcase
    end

endmodule

// File: rtl/fnd_scan_drv.sv
// Two-digit multiplexed 7-segment driver: a free-running binary-to-BCD
// converter feeds digit registers that a scan counter alternates onto seg/com.
module fnd_scan_drv
    import fnd_pkg::*;
#(
    parameter logic [31:0] SCAN_DIV = 32'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] in_val,
    output logic [6:0] seg,
    output logic [1:0] com,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo
);

    conv_state_t state_r;
    conv_state_t state_nx_s;
    logic        load_s;
    logic        shift_en_s;
    logic        commit_s;

    logic [13:0] shift_r;
    logic [13:0] shift_adj_s;
    logic [2:0]  bit_cnt_r;

    logic [31:0] scan_cnt_r;
    logic        scan_wrap_s;
    logic        sel_r;
    logic        sel_nx_s;

    logic [3:0]  digit_hi_r;
    logic [3:0]  digit_lo_r;
    logic [3:0]  hi_nx_s;
    logic [3:0]  lo_nx_s;
    logic [3:0]  mux_digit_s;
    logic [6:0]  dec_seg_s;
    logic [6:0]  seg_r;
    logic [1:0]  com_r;

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Conversion FSM next-state logic.
    always_comb begin
        state_nx_s = IDLE;
        case (state_r)
            IDLE: state_nx_s = CONV;
            CONV: begin
                if (bit_cnt_r == CONV_LAST) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = CONV;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Conversion FSM datapath controls.
    always_comb begin
        load_s     = 1'b0;
        shift_en_s = 1'b0;
        commit_s   = 1'b0;
        case (state_r)
            IDLE:    load_s     = 1'b1;
            CONV:    shift_en_s = 1'b1;
            DONE:    commit_s   = 1'b1;
            default: load_s     = 1'b0;
        endcase
    end

    assign shift_adj_s = {bcd_adjust(shift_r[13:6]), shift_r[5:0]};

    // Shift register {bcd, bin} and step counter; in_val is captured only on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r   <= 14'd0;
            bit_cnt_r <= 3'd0;
        end else if (load_s) begin
            shift_r   <= {8'd0, in_val};
            bit_cnt_r <= 3'd0;
        end else if (shift_en_s) begin
            shift_r   <= shift_adj_s << 3'd1;
            bit_cnt_r <= bit_cnt_r + 3'd1;
        end else begin
            shift_r   <= shift_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    assign scan_wrap_s = (scan_cnt_r == (SCAN_DIV - 32'd1));

    // Scan divider and digit select.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_r <= 32'd0;
            sel_r      <= 1'b0;
        end else if (scan_wrap_s) begin
            scan_cnt_r <= 32'd0;
            sel_r      <= ~sel_r;
        end else begin
            scan_cnt_r <= scan_cnt_r + 32'd1;
            sel_r      <= sel_r;
        end
    end

    // Values the digit and select registers take on this edge, so seg/com
    // track a simultaneous digit update and select toggle without lag.
    always_comb begin
        if (scan_wrap_s) begin
            sel_nx_s = ~sel_r;
        end else begin
            sel_nx_s = sel_r;
        end
        if (commit_s) begin
            hi_nx_s = shift_r[13:10];
            lo_nx_s = shift_r[9:6];
        end else begin
            hi_nx_s = digit_hi_r;
            lo_nx_s = digit_lo_r;
        end
        if (sel_nx_s) begin
            mux_digit_s = hi_nx_s;
        end else begin
            mux_digit_s = lo_nx_s;
        end
    end

    bcd2seg u_bcd2seg (
        .bcd (mux_digit_s),
        .seg (dec_seg_s)
    );

    // Digit and display output registers with tens-digit zero blanking.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_hi_r <= 4'd0;
            digit_lo_r <= 4'd0;
            com_r      <= 2'b10;
            seg_r      <= SEG_0;
        end else begin
            digit_hi_r <= hi_nx_s;
            digit_lo_r <= lo_nx_s;
            com_r      <= sel_nx_s ? 2'b01 : 2'b10;
            seg_r      <= (sel_nx_s && (hi_nx_s == 4'd0)) ? BLANK : dec_seg_s;
        end
    end

    assign digit_hi = digit_hi_r;
    assign digit_lo = digit_lo_r;
    assign seg      = seg_r;
    assign com      = com_r;

endmodule
